// File: rtl/macc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : macc_pkg
// Description : Shared types and constants for the MACC datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package macc_pkg;

    localparam int MULT_N = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // {Q[0], Q_1} pairs that trigger an add or a subtract of the multiplicand
    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage : macc_pkg
`default_nettype wire

// File: rtl/mux2to1.sv
`default_nettype none
// ============================================================================
// Module      : mux2to1
// Description : Parameterised 2-to-1 multiplexer cell.
// Revision    : 1.0 - initial release
// ============================================================================
module mux2to1 #(
    parameter int N = 8
) (
    input  logic [N-1:0] i_in0,
    input  logic [N-1:0] i_in1,
    input  logic         i_sel,
    output logic [N-1:0] o_out
);

    assign o_out = i_sel ? i_in1 : i_in0;

endmodule : mux2to1
`default_nettype wire

// File: rtl/booth_seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : booth_seq_multiplier
// Description : Sequential radix-2 Booth signed multiplier, one step per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module booth_seq_multiplier
    import macc_pkg::*;
#(
    parameter int N = MULT_N
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N-1:0]     A,
    input  logic [N-1:0]     B,
    output logic             busy,
    output logic             done,
    output logic [2*N-1:0]   P
);

    localparam int CW = (N > 2) ? $clog2(N) : 1;

    state_t          state_q, state_d;
    logic [N:0]      m_q, m_d;
    logic [N:0]      acc_q, acc_d;
    logic [N-1:0]    q_q, q_d;
    logic            q1_q, q1_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [2*N-1:0]  p_q, p_d;

    logic [1:0]      booth_code;
    logic            sub_sel;
    logic [N:0]      operand;
    logic [N:0]      sum;
    logic [N:0]      step_acc;

    assign booth_code = {q_q[0], q1_q};
    assign sub_sel    = q_q[0] & ~q1_q;

    // Subtraction is ~M plus a carry-in of one, so the select doubles as carry
    mux2to1 #(
        .N (N + 1)
    ) u_addsub_mux (
        .i_in0 (m_q),
        .i_in1 (~m_q),
        .i_sel (sub_sel),
        .o_out (operand)
    );

    assign sum      = acc_q + operand + {{N{1'b0}}, sub_sel};
    assign step_acc = ((booth_code == BOOTH_ADD) || (booth_code == BOOTH_SUB)) ? sum : acc_q;

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        acc_d   = acc_q;
        q_d     = q_q;
        q1_d    = q1_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CALC;
                    m_d     = {A[N-1], A};
                    acc_d   = '0;
                    q_d     = B;
                    q1_d    = 1'b0;
                    cnt_d   = '0;
                end
            end
            CALC: begin
                // Arithmetic right shift of {ACC, Q, Q_1}
                acc_d = {step_acc[N], step_acc[N:1]};
                q_d   = {step_acc[0], q_q[N-1:1]};
                q1_d  = q_q[0];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                p_d     = {acc_q[N-1:0], q_q};
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == CALC);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            m_q     <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            q1_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            q1_q    <= q1_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            p_q     <= p_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign P    = p_q;

endmodule : booth_seq_multiplier
`default_nettype wire

// File: tb/tb_booth_seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : tb_booth_seq_multiplier
// Description : Self-checking bench for booth_seq_multiplier (N = 8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_seq_multiplier;

    localparam int N = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [N-1:0]     A;
    logic [N-1:0]     B;
    logic             busy;
    logic             done;
    logic [2*N-1:0]   P;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_start_cyc = 0;

    booth_seq_multiplier #(
        .N (N)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .P     (P)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain signed product truncated to 2N bits
    function automatic logic [2*N-1:0] ref_prod(input logic signed [N-1:0] a,
                                                input logic signed [N-1:0] b);
        int p;
        p = int'(a) * int'(b);
        return p[2*N-1:0];
    endfunction

    // Called at a negedge; injects extra start pulses (with A=9,B=9) at the
    // listed cycle offsets after acceptance, which must all be ignored.
    task automatic do_mult(input logic signed [N-1:0] a, input logic signed [N-1:0] b,
                           input string tag, input int inj0, input int inj1);
        int cycles;
        int busy_cnt;
        logic [2*N-1:0] exp_p;
        exp_p = ref_prod(a, b);
        A = a;
        B = b;
        start = 1'b1;
        last_start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        A = 8'd9;
        B = 8'd9;
        cycles = 0;
        busy_cnt = 0;
        while (!done && cycles < 40) begin
            if (busy) busy_cnt++;
            start = (cycles == inj0) || (cycles == inj1);
            @(negedge clk);
            cycles++;
            if (busy && done) check({tag, "_busy_done_overlap"}, 1, 0);
        end
        start = 1'b0;
        check({tag, "_latency"}, cycles, N + 1);
        check({tag, "_busy_cycles"}, busy_cnt, N);
        check({tag, "_P"}, P, exp_p);
    endtask

    initial begin
        logic [2*N-1:0] held;
        int start1;
        int extra_done;
        logic signed [N-1:0] corners [6];
        corners = '{-8'sd128, -8'sd127, -8'sd1, 8'sd0, 8'sd1, 8'sd127};

        rst = 1'b1;
        start = 1'b0;
        A = '0;
        B = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_P", P, 0);
        rst = 1'b0;
        @(negedge clk);

        do_mult(8'sd3, 8'sd5, "p3x5", -1, -1);
        check("p3x5_value", P, 16'h000F);
        @(negedge clk);
        check("done_single_cycle", done, 0);

        do_mult(-8'sd128, -8'sd128, "pmin_min", -1, -1);
        check("pmin_min_value", P, 16'h4000);
        do_mult(-8'sd128, 8'sd127, "pmin_max", -1, -1);
        check("pmin_max_value", P, 16'hC080);
        do_mult(8'sd127, 8'sd127, "pmax_max", -1, -1);
        check("pmax_max_value", P, 16'd16129);
        do_mult(8'sd0, -8'sd77, "p0xm77", -1, -1);
        check("p0xm77_value", P, 16'h0000);
        do_mult(-8'sd1, -8'sd1, "pm1xm1", -1, -1);
        check("pm1xm1_value", P, 16'h0001);

        held = P;
        extra_done = 0;
        repeat (20) begin
            @(negedge clk);
            if (done || busy) extra_done++;
        end
        check("hold_P", P, held);
        check("hold_idle", extra_done, 0);

        // Starts during CALC and during DONE must be ignored
        do_mult(8'sd6, -8'sd7, "inject", 3, N);
        check("inject_value", P, 16'hFFD6);
        extra_done = 0;
        repeat (15) begin
            @(negedge clk);
            if (done || busy) extra_done++;
        end
        check("inject_no_second_op", extra_done, 0);
        check("inject_P_held", P, 16'hFFD6);

        // Asynchronous reset in the middle of a run
        A = 8'sd100;
        B = 8'sd50;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_reset_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_done", done, 0);
        check("async_rst_P", P, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_mult(-8'sd3, 8'sd4, "post_reset", -1, -1);
        check("post_reset_value", P, 16'hFFF4);

        // Back-to-back: next start issued in the cycle done is high
        @(negedge clk);
        do_mult(8'sd11, -8'sd13, "b2b_first", -1, -1);
        start1 = last_start_cyc;
        do_mult(-8'sd25, -8'sd5, "b2b_second", -1, -1);
        check("b2b_throughput", last_start_cyc - start1, N + 2);

        foreach (corners[i]) begin
            foreach (corners[j]) begin
                do_mult(corners[i], corners[j], "corner", -1, -1);
            end
        end

        for (int k = 0; k < 300; k++) begin
            logic [N-1:0] ra;
            logic [N-1:0] rb;
            ra = N'($urandom);
            rb = N'($urandom);
            do_mult(ra, rb, "rand", -1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_booth_seq_multiplier
`default_nettype wire
